// File: rtl/seq_detector_jk.sv
// Serial pattern detector whose state register is described in JK excitation form.
// Next-state values come from a prefix-match table that is folded at elaboration time.
module seq_detector_jk #(
   parameter int              PLEN    = 4,
   parameter logic [PLEN-1:0] PATTERN = 4'b1011,
   parameter bit              OVERLAP = 1'b1,
   parameter int              CNT_W   = 8,
   parameter int              SW      = $clog2(PLEN + 1)
) (
   input  logic             CLK,
   input  logic             Reset,
   input  logic             En,
   input  logic             X,
   input  logic             Clr,
   output logic             Z,
   output logic [SW-1:0]    State,
   output logic [SW-1:0]    J,
   output logic [SW-1:0]    K,
   output logic [CNT_W-1:0] Count
);

   localparam int              NS      = PLEN + 1;
   localparam int              TBL_W   = 2 * NS * SW;
   localparam logic [SW-1:0]   FULL    = SW'(PLEN);
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   // Entry (2*k + x) holds the longest pattern prefix that is a suffix of
   // (first k pattern bits, x); the full-match row restarts from S0 when
   // overlapping matches are not allowed.
   function automatic logic [TBL_W-1:0] build_delta();
      logic [TBL_W-1:0] tbl;
      logic [8:0]       seq;
      int               k0;
      int               best;
      bit               hit;
      tbl = '0;
      for (int k = 0; k <= PLEN; k++) begin
         for (int b = 0; b < 2; b++) begin
            if ((k == PLEN) && (OVERLAP == 1'b0)) begin
               k0 = 0;
            end else begin
               k0 = k;
            end
            seq = 9'b0;
            for (int j = 0; j < k0; j++) begin
               seq[j] = PATTERN[PLEN-1-j];
            end
            seq[k0] = (b != 0) ? 1'b1 : 1'b0;
            best = 0;
            for (int l = 1; l <= k0 + 1; l++) begin
               if (l <= PLEN) begin
                  hit = 1'b1;
                  for (int m = 0; m < l; m++) begin
                     if (seq[k0+1-l+m] != PATTERN[PLEN-1-m]) begin
                        hit = 1'b0;
                     end else begin
                        hit = hit;
                     end
                  end
                  if (hit) begin
                     best = l;
                  end else begin
                     best = best;
                  end
               end else begin
                  best = best;
               end
            end
            tbl[(2*k+b)*SW +: SW] = best[SW-1:0];
         end
      end
      return tbl;
   endfunction

   localparam logic [TBL_W-1:0] DELTA_TBL = build_delta();

   logic [SW-1:0]    state_r;
   logic             z_r;
   logic [CNT_W-1:0] count_r;
   logic [SW-1:0]    next_s;
   logic [SW-1:0]    j_s;
   logic [SW-1:0]    k_s;
   logic             hit_s;

   // Next-state lookup; unreachable encodings above S{PLEN} recover to S0.
   always_comb begin
      next_s = '0;
      if (state_r <= FULL) begin
         next_s = DELTA_TBL[(2*int'(state_r) + int'(X))*SW +: SW];
      end else begin
         next_s = '0;
      end
      hit_s = (next_s == FULL);
   end

   // JK excitation with don't-cares resolved to 0; idle or reset gives J=K=0.
   always_comb begin
      j_s = '0;
      k_s = '0;
      if (Reset && En) begin
         j_s = ~state_r & next_s;
         k_s = state_r & ~next_s;
      end else begin
         j_s = '0;
         k_s = '0;
      end
   end

   // State register and registered match flag, advancing only on enabled samples.
   always_ff @(posedge CLK or negedge Reset) begin
      if (!Reset) begin
         state_r <= '0;
         z_r     <= 1'b0;
      end else if (En) begin
         state_r <= next_s;
         z_r     <= hit_s;
      end
   end

   // Saturating match counter; a clear takes priority over an increment.
   always_ff @(posedge CLK or negedge Reset) begin
      if (!Reset) begin
         count_r <= '0;
      end else if (Clr) begin
         count_r <= '0;
      end else if (En && hit_s && (count_r != CNT_MAX)) begin
         count_r <= count_r + CNT_W'(1);
      end
   end

   assign State = state_r;
   assign Z     = z_r;
   assign Count = count_r;
   assign J     = j_s;
   assign K     = k_s;

endmodule
